uart_tx_ctrl: RTL and testbench

- Transmit-side sequencer for the APB3 UART.
- Accepts one data word per valid/ready handshake from the TX FIFO or register file.
- Generates bit timing from a programmable baud divisor and drives the serial line through a frame FSM: start, data (LSB first), optional parity, 1 or 2 stop bits.
- Reports busy and frame-done status to the register/IRQ logic.

---
 rtl/uart_tx_ctrl.sv | 110 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer (start, data LSB first, optional parity, 1/2 stop bits).
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              i_apb_pclk,
  input  logic              i_apb_presetn,
  input  logic              i_enable,
  input  logic [DIV_W-1:0]  i_baud_div,
  input  logic              i_stop2,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
`ifdef UART_TX_PARITY_EN
  input  logic              i_parity_en,
  input  logic              i_parity_odd,
`endif
  output logic              o_ready,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done
);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  logic [2:0]        state;
  logic [DIV_W-1:0]  baud_cnt, div_q;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              stop2_q, has_par, par_bit;
  assign o_ready = (state == IDLE) & i_enable;
  assign o_busy  = state != IDLE;
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge i_apb_pclk or negedge i_apb_presetn)
    if (!i_apb_presetn) begin
      has_par <= 1'b0;
      par_bit <= 1'b0;
    end else if (i_valid && o_ready) begin
      has_par <= i_parity_en;
      par_bit <= ^i_data ^ i_parity_odd;
    end
`else
  assign has_par = 1'b0;
  assign par_bit = 1'b0;
`endif
  // bit_idx doubles as the stop-bit counter while in STOP
  always_ff @(posedge i_apb_pclk or negedge i_apb_presetn)
    if (!i_apb_presetn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      div_q    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      stop2_q  <= 1'b0;
      o_tx     <= 1'b1;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state == IDLE) begin
        if (i_valid && o_ready) begin
          state    <= START;
          o_tx     <= 1'b0;
          baud_cnt <= i_baud_div;
          div_q    <= i_baud_div;
          stop2_q  <= i_stop2;
          shreg    <= i_data;
        end
      end else if (baud_cnt != '0) begin
        baud_cnt <= baud_cnt - DIV_W'(1);
      end else begin
        baud_cnt <= div_q;
        bit_idx  <= '0;
        case (state)
          START: begin
            state <= DATA;
            o_tx  <= shreg[0];
            shreg <= shreg >> 1;
          end
          DATA:
            if (bit_idx == IDX_W'(DATA_W - 1)) begin
              state <= has_par ? PARITY : STOP;
              o_tx  <= has_par ? par_bit : 1'b1;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              o_tx    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          PARITY: begin
            state <= STOP;
            o_tx  <= 1'b1;
          end
          STOP:
            if (bit_idx == IDX_W'(stop2_q)) begin
              state  <= IDLE;
              o_tx   <= 1'b1;
              o_done <= 1'b1;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          default: begin
            state <= IDLE;
            o_tx  <= 1'b1;
          end
        endcase
      end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed + randomized frames checked against a bit-list model of the UART frame.
module tb_uart_tx_ctrl;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, stop2 = 1'b0, valid = 1'b0;
  logic [DIV_W-1:0]  div = '0;
  logic [DATA_W-1:0] data = '0;
`ifdef UART_TX_PARITY_EN
  logic par_en = 1'b0, par_odd = 1'b0;
`endif
  logic ready, tx, busy, done;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .i_apb_pclk(clk),
    .i_apb_presetn(rst_n),
    .i_enable(en),
    .i_baud_div(div),
    .i_stop2(stop2),
    .i_data(data),
    .i_valid(valid),
`ifdef UART_TX_PARITY_EN
    .i_parity_en(par_en),
    .i_parity_odd(par_odd),
`endif
    .o_ready(ready),
    .o_tx(tx),
    .o_busy(busy),
    .o_done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the o_done cycle.
  task automatic frame(input logic [DATA_W-1:0] d, input int dv, input bit s2, input bit pe,
                       input bit po, input bit hold, input bit drop_en);
    logic bits[$];
    int len;
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(^d ^ po);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    len = bits.size() * (dv + 1);
    data  = d;
    div   = DIV_W'(dv);
    stop2 = s2;
    valid = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_en  = pe;
    par_odd = po;
`endif
    check("ready_at_accept", ready, 1);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      check("tx_bit", tx, bits[c / (dv + 1)]);
      check("busy_mid", busy, 1);
      check("done_mid", done, 0);
      check("ready_mid", ready, 0);
      if (c == 0) begin
        valid = hold;
        data  = DATA_W'($urandom);
        div   = DIV_W'($urandom_range(0, 20));
        stop2 = ~s2;
`ifdef UART_TX_PARITY_EN
        par_en  = ~pe;
        par_odd = ~po;
`endif
      end
      if (drop_en && c == len / 2) en = 1'b0;
    end
    @(negedge clk);
    check("done_end", done, 1);
    check("tx_end", tx, 1);
    check("busy_end", busy, 0);
    valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pe;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready_dis", ready, 0);
    en = 1'b1;
    #1 check("rst_ready_en", ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", ready, 1);
    check("idle_tx", tx, 1);
    frame(8'hA5, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    frame(8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(8'hFF, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    frame(DATA_W'($urandom), 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frame(DATA_W'($urandom), 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef UART_TX_PARITY_EN
    frame(8'h07, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'h07, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
    for (int k = 0; k < 12; k++) begin
      pe = 1'b0;
`ifdef UART_TX_PARITY_EN
      pe = 1'($urandom_range(0, 1));
`endif
      frame(DATA_W'($urandom), $urandom_range(0, 6), 1'($urandom_range(0, 1)), pe,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    frame(DATA_W'($urandom), 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("endrop_ready", ready, 0);
      check("endrop_tx", tx, 1);
      check("endrop_busy", busy, 0);
    end
    valid = 1'b0;
    en = 1'b1;
    @(negedge clk);
    data  = DATA_W'($urandom);
    div   = DIV_W'(3);
    stop2 = 1'b0;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_tx", tx, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_tx", tx, 1);
      check("post_rst_ready", ready, 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
